net_packet_rx: RTL and testbench

NET_PACKET_RX -- requirements
Module: net_packet_rx

---
 rtl/net_packet_rx.sv | 171 +++++++++++++++++
 tb/tb_net_packet_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/net_packet_rx.sv
// Network packet receiver: filters packets addressed to this node, queues
// legal ones in a small FIFO and replays them as one-cycle write strobes
// toward instruction memory, register file, barrier mask or PC.
module net_packet_rx #(
  parameter logic [9:0] MY_ID  = 10'd1,
  parameter int         MASK_W = 3,
  parameter int         DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [59:0]       net_packet_flat_i,
  input  logic              sink_ready_i,
  output logic              imem_wen_o,
  output logic [9:0]        imem_addr_o,
  output logic [15:0]       imem_data_o,
  output logic              rf_wen_o,
  output logic [5:0]        rf_addr_o,
  output logic [31:0]       rf_data_o,
  output logic              bar_wen_o,
  output logic [MASK_W-1:0] bar_mask_o,
  output logic              pc_wen_o,
  output logic [9:0]        pc_o,
  output logic              run_o,
  output logic              overflow_o,
  output logic              error_o,
  output logic [15:0]       pkt_count_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  typedef enum logic {S_HALT, S_RUN} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] data;
    logic [9:0]  addr;
  } entry_t;

  // Packet fields; the reserved bits are deliberately ignored.
  logic [9:0]  w_id;
  logic [2:0]  w_op;
  logic [31:0] w_data;
  logic [9:0]  w_addr;
  logic        w_unused_rsvd;

  assign w_id          = net_packet_flat_i[59:50];
  assign w_op          = net_packet_flat_i[49:47];
  assign w_data        = net_packet_flat_i[41:10];
  assign w_addr        = net_packet_flat_i[9:0];
  assign w_unused_rsvd = &{1'b0, net_packet_flat_i[46:42]};

  logic w_match, w_accept, w_illegal_op;

  assign w_match      = (w_id == MY_ID);
  assign w_accept     = w_match && (w_op != OP_NULL) && (w_op <= OP_BAR);
  assign w_illegal_op = w_match && (w_op > OP_BAR);

  // FIFO storage and pointers; the extra MSB separates full from empty.
  entry_t        r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_push, w_drop;
  entry_t        w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && sink_ready_i;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push  = w_accept && (!w_full || w_pop);
  assign w_drop  = w_accept && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Write accepted packets into the FIFO storage.
  // NOTE: storage is not reset; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= '{op: w_op, data: w_data, addr: w_addr};
    end
  end

  // FIFO pointers, sticky flags and the accepted-packet counter.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // see pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      overflow_o  <= 1'b0;
      pkt_count_o <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) overflow_o <= 1'b1;
      if (w_push && (pkt_count_o != 16'hFFFF)) pkt_count_o <= pkt_count_o + 16'd1;
    end
  end

  state_e r_state, w_state_nxt;
  logic   w_imem_wen, w_rf_wen, w_bar_wen, w_pc_wen, w_run_err;

  // HALT/RUN state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_HALT;
    else        r_state <= w_state_nxt;
  end

  // Decode the FIFO head on a pop into next state and strobe requests.
  // NOTE: defaults first, so every path assigns every output and no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    w_imem_wen  = 1'b0;
    w_rf_wen    = 1'b0;
    w_bar_wen   = 1'b0;
    w_pc_wen    = 1'b0;
    w_run_err   = 1'b0;
    if (w_pop) begin
      unique case (w_head.op)
        OP_INSTR: if (r_state == S_RUN) w_run_err = 1'b1; else w_imem_wen = 1'b1;
        OP_REG:   if (r_state == S_RUN) w_run_err = 1'b1; else w_rf_wen   = 1'b1;
        OP_PC: begin
          w_pc_wen    = 1'b1;
          w_state_nxt = w_head.data[0] ? S_RUN : S_HALT;
        end
        OP_BAR:   w_bar_wen = 1'b1;
        default:  ;
      endcase
    end
  end

  assign run_o = (r_state == S_RUN);

  // Registered strobes; data outputs only move when their strobe fires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_wen_o  <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      rf_wen_o    <= 1'b0;
      rf_addr_o   <= '0;
      rf_data_o   <= '0;
      bar_wen_o   <= 1'b0;
      bar_mask_o  <= '0;
      pc_wen_o    <= 1'b0;
      pc_o        <= '0;
      error_o     <= 1'b0;
    end else begin
      imem_wen_o <= w_imem_wen;
      rf_wen_o   <= w_rf_wen;
      bar_wen_o  <= w_bar_wen;
      pc_wen_o   <= w_pc_wen;
      if (w_imem_wen) begin
        imem_addr_o <= w_head.addr;
        imem_data_o <= w_head.data[15:0];
      end
      if (w_rf_wen) begin
        rf_addr_o <= w_head.addr[5:0];
        rf_data_o <= w_head.data;
      end
      if (w_bar_wen) bar_mask_o <= w_head.data[MASK_W-1:0];
      if (w_pc_wen)  pc_o       <= w_head.addr;
      if (w_illegal_op || w_run_err) error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_net_packet_rx.sv
// Scoreboard bench for net_packet_rx: stimulus pushes expected strobes into a
// queue, a negedge monitor pops and compares whenever a strobe appears.
module tb_net_packet_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [59:0] net_packet_flat_i;
  logic        sink_ready_i;
  logic        imem_wen_o, rf_wen_o, bar_wen_o, pc_wen_o;
  logic [9:0]  imem_addr_o, pc_o;
  logic [15:0] imem_data_o;
  logic [5:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [2:0]  bar_mask_o;
  logic        run_o, overflow_o, error_o;
  logic [15:0] pkt_count_o;

  net_packet_rx dut (
    .clk(clk), .reset(reset),
    .net_packet_flat_i(net_packet_flat_i), .sink_ready_i(sink_ready_i),
    .imem_wen_o(imem_wen_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .rf_wen_o(rf_wen_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .bar_wen_o(bar_wen_o), .bar_mask_o(bar_mask_o),
    .pc_wen_o(pc_wen_o), .pc_o(pc_o),
    .run_o(run_o), .overflow_o(overflow_o), .error_o(error_o),
    .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_NULL = 3'd0, OP_INSTR = 3'd1, OP_REG = 3'd2,
                         OP_PC = 3'd3, OP_BAR = 3'd4;

  typedef enum logic [1:0] {K_IMEM, K_RF, K_BAR, K_PC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
    logic [9:0]  addr;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void expect_w(input kind_e k, input logic [31:0] d, input logic [9:0] a);
    exp_t e;
    e.kind = k; e.data = d; e.addr = a;
    q.push_back(e);
  endfunction

  // Monitor: every cycle with a strobe must match the oldest expected write.
  always @(negedge clk) begin
    int   n_wen;
    kind_e k;
    exp_t e;
    n_wen = int'(imem_wen_o) + int'(rf_wen_o) + int'(bar_wen_o) + int'(pc_wen_o);
    if (n_wen > 1) check("one_hot_strobe", 32'(n_wen), 32'd1);
    if (n_wen != 0) begin
      if (imem_wen_o)     k = K_IMEM;
      else if (rf_wen_o)  k = K_RF;
      else if (bar_wen_o) k = K_BAR;
      else                k = K_PC;
      if (q.size() == 0) begin
        check("unexpected_strobe", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("strobe_kind", 32'(k), 32'(e.kind));
        if (k == e.kind) begin
          unique case (k)
            K_IMEM: begin
              check("imem_addr", 32'(imem_addr_o), 32'(e.addr));
              check("imem_data", 32'(imem_data_o), 32'(e.data[15:0]));
            end
            K_RF: begin
              check("rf_addr", 32'(rf_addr_o), 32'(e.addr[5:0]));
              check("rf_data", rf_data_o, e.data);
            end
            K_BAR: check("bar_mask", 32'(bar_mask_o), 32'(e.data[2:0]));
            K_PC:  check("pc", 32'(pc_o), 32'(e.addr));
          endcase
        end
      end
    end
  end

  // Drive a packet for one edge (called in the posedge+1 phase).
  task automatic send(input logic [9:0] id, input logic [2:0] op,
                      input logic [31:0] data, input logic [9:0] addr);
    net_packet_flat_i = {id, op, 5'b10101, data, addr};
    @(posedge clk); #1;
    net_packet_flat_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      idle(1);
      cyc++;
    end
    idle(2);
    check(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset             = 1'b0;
    sink_ready_i      = 1'b1;
    net_packet_flat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", {imem_wen_o, rf_wen_o, bar_wen_o, pc_wen_o}, 32'd0);
    check("rst_flags", {run_o, overflow_o, error_o}, 32'd0);
    check("rst_count", 32'(pkt_count_o), 32'd0);
    check("rst_data", imem_addr_o | imem_data_o | rf_data_o | pc_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic INSTR write and its two-edge latency.
    expect_w(K_IMEM, 32'h0000_A5C3, 10'd3);
    send(10'd1, OP_INSTR, 32'h0000_A5C3, 10'd3);
    @(negedge clk);
    check("lat_early", 32'(imem_wen_o), 32'd0);
    @(negedge clk);
    check("lat_strobe", 32'(imem_wen_o), 32'd1);
    check("count_instr", 32'(pkt_count_o), 32'd1);
    @(posedge clk); #1;

    // Wrong ID and NULL op are ignored.
    send(10'd2, OP_INSTR, 32'h1234, 10'd1);
    send(10'd1, OP_NULL, 32'h1234, 10'd1);
    idle(3);
    check("ignored_count", 32'(pkt_count_o), 32'd1);
    check("ignored_err", 32'(error_o), 32'd0);

    // REG then PC start; REG while running is rejected.
    expect_w(K_RF, 32'hDEAD_BEEF, 10'd5);
    send(10'd1, OP_REG, 32'hDEAD_BEEF, 10'd5);
    expect_w(K_PC, 32'd5, 10'd0);
    send(10'd1, OP_PC, 32'd5, 10'd0);
    idle(4);
    check("run_after_pc", 32'(run_o), 32'd1);
    check("err_before_reg", 32'(error_o), 32'd0);
    send(10'd1, OP_REG, 32'd1, 10'd7);
    idle(4);
    check("err_reg_in_run", 32'(error_o), 32'd1);
    check("rf_addr_hold", 32'(rf_addr_o), 32'd5);
    check("count_after_reg", 32'(pkt_count_o), 32'd4);

    // Reset, then illegal op 6 with matching ID.
    pulse_reset();
    check("rst2_run", 32'(run_o), 32'd0);
    check("rst2_err", 32'(error_o), 32'd0);
    send(10'd1, 3'd6, 32'h1, 10'd1);
    idle(3);
    check("illegal_err", 32'(error_o), 32'd1);
    check("illegal_count", 32'(pkt_count_o), 32'd0);

    // Overflow: five BARs into a stalled 4-deep FIFO.
    sink_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_w(K_BAR, 32'(i), 10'd0);
      send(10'd1, OP_BAR, 32'(i), 10'd0);
    end
    idle(2);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(pkt_count_o), 32'd4);
    sink_ready_i = 1'b1;
    drain("ovf_drain");

    // Full FIFO with simultaneous pop and push.
    pulse_reset();
    sink_ready_i = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      expect_w(K_BAR, 32'(i), 10'd0);
      send(10'd1, OP_BAR, 32'(i), 10'd0);
    end
    check("full_no_ovf", 32'(overflow_o), 32'd0);
    sink_ready_i = 1'b1;
    expect_w(K_BAR, 32'd6, 10'd0);
    send(10'd1, OP_BAR, 32'd6, 10'd0);
    check("popush_no_ovf", 32'(overflow_o), 32'd0);
    check("popush_count", 32'(pkt_count_o), 32'd5);
    drain("popush_drain");

    // Reset while running with queued packets.
    expect_w(K_PC, 32'd1, 10'd9);
    send(10'd1, OP_PC, 32'd1, 10'd9);
    drain("pc_drain");
    check("run_before_rst", 32'(run_o), 32'd1);
    sink_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(10'd1, OP_BAR, 32'(i), 10'd0);
    send(10'd1, 3'd7, 32'd0, 10'd0);
    idle(1);
    check("err_before_rst", 32'(error_o), 32'd1);
    reset = 1'b0;
    send(10'd1, OP_BAR, 32'd3, 10'd0);
    check("rst3_run", 32'(run_o), 32'd0);
    check("rst3_flags", {overflow_o, error_o}, 32'd0);
    check("rst3_count", 32'(pkt_count_o), 32'd0);
    check("rst3_pc", 32'(pc_o), 32'd0);
    reset        = 1'b1;
    sink_ready_i = 1'b1;
    idle(8);
    check("rst3_count_after", 32'(pkt_count_o), 32'd0);
    check("final_queue", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
